instr_fetch_stage: RTL

Instruction fetch stage for the MIPS pipelined CPU: holds the program counter, drives the instruction-memory address, and registers the fetched word with its PC+4 into an IF/ID pipeline register. It sits directly upstream of the main decoder; `opcode_o` feeds the decoder's 6-bit opcode input. Stall and redirect inputs come from later stages (hazard unit, branch resolution).

---
 rtl/instr_fetch_stage_if.sv | 29 ++
 rtl/instr_fetch_stage.sv | 71 +++++++
 2 files changed

// File: rtl/instr_fetch_stage_if.sv
// Purpose: bundles the fetch stage's control, instruction-memory and IF/ID
// signals into one interface.
// Ports (via modports):
//   master - the fetch stage. It drives the imem address and the IF/ID outputs,
//            and receives stall, redirect and imem data.
//   slave  - the environment around the fetch stage: hazard unit, branch
//            resolution, instruction memory and decoder.
interface instr_fetch_stage_if;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic [31:0] instr_o;
  logic [5:0]  opcode_o;
  logic [31:0] pc_plus4_o;
  logic        valid_o;
  logic [31:0] fetch_count_o;

  modport master (
    input  stall_i, redirect_i, redirect_pc_i, imem_data_i,
    output imem_addr_o, instr_o, opcode_o, pc_plus4_o, valid_o, fetch_count_o
  );

  modport slave (
    output stall_i, redirect_i, redirect_pc_i, imem_data_i,
    input  imem_addr_o, instr_o, opcode_o, pc_plus4_o, valid_o, fetch_count_o
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// Purpose: MIPS instruction fetch stage. It holds the PC and drives the imem
// address, then registers the fetched word and PC+4 into the IF/ID register.
// Ports:
//   clk_i - rising-edge clock
//   rst_i - asynchronous active-low reset
//   bus   - instr_fetch_stage_if.master. It carries:
//           - stall/redirect control and the redirect target
//           - the combinational imem address and read data
//           - the IF/ID outputs: instr, opcode, pc+4, valid, fetch count
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  instr_fetch_stage_if.master        bus
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_INIT = {RESET_PC[XLEN-1:2], 2'b00};

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next_seq;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pc_plus4_q;
  logic            valid_q;
  logic [XLEN-1:0] fetch_count;
  logic [1:0]      unused_redirect_lsbs;

  // Sequential PC; wraps modulo 2^32.
  assign pc_next_seq = pc + XLEN'(4);

  // Redirect beats stall; stall freezes PC and IF/ID; otherwise advance.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc         <= PC_INIT;
      instr_q    <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (bus.redirect_i) begin
      pc         <= {bus.redirect_pc_i[XLEN-1:2], 2'b00};
      instr_q    <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (!bus.stall_i) begin
      pc         <= pc_next_seq;
      instr_q    <= bus.imem_data_i;
      pc_plus4_q <= pc_next_seq;
      valid_q    <= 1'b1;
    end
  end

  // Count a held instruction only when downstream actually consumes it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_count <= '0;
    end else if (valid_q && !bus.stall_i && !bus.redirect_i) begin
      fetch_count <= fetch_count + XLEN'(1);
    end
  end

  // Word alignment makes the redirect target's low bits irrelevant.
  assign unused_redirect_lsbs = bus.redirect_pc_i[1:0];

  assign bus.imem_addr_o   = pc;
  assign bus.instr_o       = instr_q;
  assign bus.opcode_o      = instr_q[31:26];
  assign bus.pc_plus4_o    = pc_plus4_q;
  assign bus.valid_o       = valid_q;
  assign bus.fetch_count_o = fetch_count;

endmodule
